delay_tap_probe: RTL

Self-test sequencer that sits directly upstream of the 8-bit, 3-stage delay-line tap stage and also consumes its output.
- Drives the stage's data input (`d_out`) and tap select (`sel_out`), and watches the selected tap output (`q_in`).
- For each tap 0..3 it flushes the line with a background value, injects a marker byte, and counts rising clock edges until the marker appears.
- It reports one measured latency per tap, plus per-tap error flags.
- Used at bring-up to confirm tap ordering and depth. For a correct stage the expected result is 1, 2, 3, 4 cycles for taps 0..3.

---
 rtl/delay_tap_probe.sv | 130 +++++++++++++
 1 files changed

// File: rtl/delay_tap_probe.sv
// Self-test sequencer for the 8-bit, 3-stage delay-line tap stage: measures marker latency per tap.
// Optional build macro DELAY_TAP_PROBE_AUTORUN_EN: repeat sweeps back-to-back after the first start.
module delay_tap_probe #(
  parameter logic [7:0]  MARKER    = 8'hA5,
  parameter logic [7:0]  BG        = 8'h00,
  parameter int unsigned FLUSH_CYC = 6,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  q_in,
  output logic [7:0]  d_out,
  output logic [1:0]  sel_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] lat,
  output logic [3:0]  err
);

  localparam int unsigned FW = $clog2(FLUSH_CYC + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);
  localparam logic [3:0]    WAIT_LAST  = 4'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        r_state;
  logic [FW-1:0] r_fcnt;
  logic [3:0]    r_wcnt;
  logic [7:0]    r_d;
  logic [1:0]    r_sel;
  logic          r_busy;
  logic          r_done;
  logic [15:0]   r_lat;
  logic [3:0]    r_err;

  logic w_go;
  logic w_hit;
  logic w_tmo;

  // In autorun, the single-cycle done level acts as the restart request.
`ifdef DELAY_TAP_PROBE_AUTORUN_EN
  assign w_go = start | r_done;
`else
  assign w_go = start;
`endif

  assign w_hit = (q_in == MARKER);
  assign w_tmo = (r_wcnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_fcnt  <= '0;
      r_wcnt  <= '0;
      r_d     <= BG;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_lat   <= '0;
      r_err   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state <= FLUSH;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_lat   <= '0;
            r_err   <= '0;
            r_sel   <= '0;
            r_d     <= BG;
            r_fcnt  <= '0;
          end
        end

        FLUSH: begin
          r_fcnt <= r_fcnt + 1'b1;
          if (r_fcnt == FLUSH_LAST) begin
            // Marker already visible after a full flush means the line is stuck.
            if (w_hit) begin
              r_err[r_sel] <= 1'b1;
            end
            r_d     <= MARKER;
            r_wcnt  <= 4'd1;
            r_state <= WAIT;
          end
        end

        WAIT: begin
          if (w_hit) begin
            r_lat[{r_sel, 2'b00} +: 4] <= r_wcnt;
          end else if (w_tmo) begin
            r_err[r_sel] <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + 4'd1;
          end

          if (w_hit || w_tmo) begin
            r_d <= BG;
            if (r_sel != 2'd3) begin
              r_sel   <= r_sel + 2'd1;
              r_fcnt  <= '0;
              r_state <= FLUSH;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_sel   <= '0;
              r_state <= IDLE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign d_out   = r_d;
  assign sel_out = r_sel;
  assign busy    = r_busy;
  assign done    = r_done;
  assign lat     = r_lat;
  assign err     = r_err;

endmodule
